// File: rtl/fp_mant_pkg.sv
// Shared significand-stage constants and types for the FP divider and multiplier
// mantissa datapaths.
package fp_mant_pkg;
   localparam int EXP_W  = 8;
   localparam int MANT_W = 23;
   localparam int SIG_W  = MANT_W + 1;
   localparam int QUO_W  = MANT_W + 3;
   localparam int CNT_W  = 5;

   // One integer quotient bit plus 25 fraction bits
   localparam logic [CNT_W-1:0] CALC_LAST = CNT_W'(QUO_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_ROUND,
      ST_DONE
   } div_state_e;

   typedef struct packed {
      logic [MANT_W-1:0] mantissa;
      logic              normalised;
      logic              round_carry;
      logic              div_by_zero;
   } div_result_t;
endpackage

// File: rtl/mantissa_div_round.sv
// Normalise and round the raw restoring-division quotient/remainder into a result.
// MANTISSA_DIV_ROUND_EN selects round-to-nearest-even; otherwise the quotient is truncated.
module mantissa_div_round
   import fp_mant_pkg::*;
(
   input  logic [QUO_W-1:0] quo,
   input  logic [QUO_W-1:0] rem,
   output div_result_t      result
);

   logic [MANT_W-1:0] mant;
`ifdef MANTISSA_DIV_ROUND_EN
   logic              guard;
   logic              sticky;
   logic              inc;
   logic [MANT_W:0]   sum;
`else
   logic              unused_trunc;
   assign unused_trunc = ^{quo[0], rem};
`endif

   always_comb begin
      mant = quo[QUO_W-1] ? quo[QUO_W-2:2] : quo[QUO_W-3:1];
      result = '0;
      result.normalised = quo[QUO_W-1];
`ifdef MANTISSA_DIV_ROUND_EN
      // Quotient bit 0 joins the sticky only when the integer bit shifts the guard up
      if (quo[QUO_W-1]) begin
         guard  = quo[1];
         sticky = quo[0] | (|rem);
      end else begin
         guard  = quo[0];
         sticky = |rem;
      end
      inc = guard & (sticky | mant[0]);
      sum = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
      result.mantissa    = sum[MANT_W-1:0];
      result.round_carry = sum[MANT_W];
`else
      result.mantissa = mant;
`endif
   end

endmodule

// File: rtl/mantissa_div_seq.sv
// Iterative radix-2 restoring divider for single-precision significands, one op in flight.
// Rounding mode is selected by MANTISSA_DIV_ROUND_EN (defined: RNE, undefined: truncate).
module mantissa_div_seq
   import fp_mant_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [EXP_W+MANT_W-1:0] a_operand,
   input  logic [EXP_W+MANT_W-1:0] b_operand,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [MANT_W-1:0]       quotient_mantissa,
   output logic                    normalised,
   output logic                    round_carry,
   output logic                    div_by_zero
);

   div_state_e        state_q, state_d;
   logic [QUO_W-1:0]  rem_q, rem_d;
   logic [QUO_W-1:0]  quo_q, quo_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SIG_W-1:0]  dvs_q, dvs_d;
   div_result_t       res_q, res_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;

   div_result_t       round_res;
   logic [QUO_W-1:0]  dvs_ext;
   logic [QUO_W-1:0]  rem_sel;
   logic              rem_ge;

   mantissa_div_round u_round (
      .quo    (quo_q),
      .rem    (rem_q),
      .result (round_res)
   );

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      cnt_d       = cnt_q;
      dvs_d       = dvs_q;
      res_d       = res_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;

      dvs_ext = {2'b00, dvs_q};
      rem_ge  = (rem_q >= dvs_ext);
      rem_sel = rem_ge ? (rem_q - dvs_ext) : rem_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               in_ready_d = 1'b0;
               // Exponent field zero means the operand is flushed to zero
               if (b_operand[EXP_W+MANT_W-1:MANT_W] == '0) begin
                  res_d             = '0;
                  res_d.div_by_zero = 1'b1;
                  out_valid_d       = 1'b1;
                  state_d           = ST_DONE;
               end else if (a_operand[EXP_W+MANT_W-1:MANT_W] == '0) begin
                  res_d       = '0;
                  out_valid_d = 1'b1;
                  state_d     = ST_DONE;
               end else begin
                  rem_d   = {2'b00, 1'b1, a_operand[MANT_W-1:0]};
                  dvs_d   = {1'b1, b_operand[MANT_W-1:0]};
                  quo_d   = '0;
                  cnt_d   = CALC_LAST;
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            rem_d = rem_sel << 1;
            quo_d = {quo_q[QUO_W-2:0], rem_ge};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               state_d = ST_ROUND;
            end
         end
         ST_ROUND: begin
            res_d       = round_res;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
         dvs_q       <= '0;
         res_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         cnt_q       <= cnt_d;
         dvs_q       <= dvs_d;
         res_q       <= res_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready          = in_ready_q;
   assign out_valid         = out_valid_q;
   assign quotient_mantissa = res_q.mantissa;
   assign normalised        = res_q.normalised;
   assign round_carry       = res_q.round_carry;
   assign div_by_zero       = res_q.div_by_zero;

endmodule

// File: tb/tb_mantissa_div_seq.sv
// Directed + random bench for mantissa_div_seq with a queue scoreboard and an
// integer-division reference model for the quotient.
module tb_mantissa_div_seq;
   import fp_mant_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [30:0] a_operand;
   logic [30:0] b_operand;
   logic        out_valid;
   logic        out_ready;
   logic [22:0] quotient_mantissa;
   logic        normalised;
   logic        round_carry;
   logic        div_by_zero;

   int vectors     = 0;
   int miscompares = 0;

`ifdef MANTISSA_DIV_ROUND_EN
   localparam bit ROUND_EN = 1'b1;
   localparam logic [22:0] THIRD_MANT = 23'h2AAAAB;
`else
   localparam bit ROUND_EN = 1'b0;
   localparam logic [22:0] THIRD_MANT = 23'h2AAAAA;
`endif

   localparam logic [30:0] F_ONE     = {8'd127, 23'h000000};
   localparam logic [30:0] F_ONEHALF = {8'd127, 23'h400000};
   localparam logic [30:0] F_MAX_SIG = {8'd127, 23'h7FFFFF};

   typedef struct {
      logic [22:0] mant;
      logic        norm;
      logic        rc;
      logic        dbz;
      int          lat;
   } exp_t;

   exp_t sb[$];

   mantissa_div_seq dut (
      .clk               (clk),
      .rst               (rst),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .a_operand         (a_operand),
      .b_operand         (b_operand),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .quotient_mantissa (quotient_mantissa),
      .normalised        (normalised),
      .round_carry       (round_carry),
      .div_by_zero       (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      vectors++;
      assert (obs === want)
      else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
      end
   endtask

   function automatic exp_t mk(input logic [22:0] m, input logic n, input logic c,
                               input logic z, input int l);
      exp_t e;
      e.mant = m; e.norm = n; e.rc = c; e.dbz = z; e.lat = l;
      return e;
   endfunction

   // Quotient computed as floor(A*2^25 / D); remainder nonzero feeds the sticky bit
   function automatic exp_t model(input logic [30:0] a, input logic [30:0] b);
      exp_t              e;
      longint unsigned   n, d, q, r;
      logic [22:0]       m;
      logic              g, s, inc;
      logic [23:0]       sum;
      e = mk(23'h0, 1'b0, 1'b0, 1'b0, 27);
      if (b[30:23] == 8'd0) begin
         e.dbz = 1'b1; e.lat = 0;
         return e;
      end
      if (a[30:23] == 8'd0) begin
         e.lat = 0;
         return e;
      end
      n = longint'({1'b1, a[22:0]}) << 25;
      d = longint'({1'b1, b[22:0]});
      q = n / d;
      r = n % d;
      if (q[25]) begin
         m = q[24:2]; g = q[1]; s = q[0] | (r != 0); e.norm = 1'b1;
      end else begin
         m = q[23:1]; g = q[0]; s = (r != 0);
      end
      inc   = ROUND_EN & g & (s | m[0]);
      sum   = {1'b0, m} + {23'd0, inc};
      e.mant = sum[22:0];
      e.rc   = sum[23];
      return e;
   endfunction

   task automatic start_op(input logic [30:0] a, input logic [30:0] b, input exp_t e);
      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
      a_operand = a;
      b_operand = b;
      in_valid  = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      a_operand = 31'($urandom);
      b_operand = 31'($urandom);
   endtask

   task automatic collect(output exp_t e);
      int lat = 0;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      e = sb.pop_front();
      chk("latency", lat, e.lat);
      chk("mantissa", {9'd0, quotient_mantissa}, {9'd0, e.mant});
      chk("flags", {29'd0, normalised, round_carry, div_by_zero}, {29'd0, e.norm, e.rc, e.dbz});
      if (out_ready) begin
         @(posedge clk); #1;
         chk("taken_out_valid", {31'd0, out_valid}, 32'd0);
         chk("taken_in_ready", {31'd0, in_ready}, 32'd1);
      end
   endtask

   task automatic run(input logic [30:0] a, input logic [30:0] b, input exp_t e);
      exp_t got;
      start_op(a, b, e);
      collect(got);
   endtask

   initial begin
      exp_t held;
      logic [30:0] ra, rb;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a_operand = '0; b_operand = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", {26'd0, in_ready, out_valid, normalised, round_carry, div_by_zero, 1'b0},
          {26'd0, 1'b1, 5'b00000});
      chk("rst_mant", {9'd0, quotient_mantissa}, 32'd0);
      rst = 1'b0;

      run(F_ONEHALF, F_ONE, mk(23'h400000, 1'b1, 1'b0, 1'b0, 27));
      run(F_ONE, F_ONEHALF, mk(THIRD_MANT, 1'b0, 1'b0, 1'b0, 27));
      run(F_ONEHALF, {8'd0, 23'h123456}, mk(23'h0, 1'b0, 1'b0, 1'b1, 0));
      run({8'd0, 23'h7FFFFF}, F_ONE, mk(23'h0, 1'b0, 1'b0, 1'b0, 0));
      run(F_MAX_SIG, F_MAX_SIG, mk(23'h0, 1'b1, 1'b0, 1'b0, 27));

      // Abort mid-CALC, then make sure no stale result ever appears
      a_operand = F_ONE; b_operand = F_ONEHALF; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("calc_busy", {30'd0, in_ready, out_valid}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_state", {29'd0, in_ready, out_valid, div_by_zero}, {29'd0, 3'b100});
      repeat (30) @(posedge clk);
      #1;
      chk("abort_no_result", {31'd0, out_valid}, 32'd0);
      run(F_ONEHALF, F_ONE, mk(23'h400000, 1'b1, 1'b0, 1'b0, 27));

      // Back-pressure: result must hold and new operands must be refused
      out_ready = 1'b0;
      start_op(F_ONE, F_ONEHALF, model(F_ONE, F_ONEHALF));
      collect(held);
      for (int i = 0; i < 20; i++) begin
         in_valid  = i[0];
         a_operand = {8'd127, 23'($urandom)};
         b_operand = {8'd127, 23'($urandom)};
         @(posedge clk); #1;
         chk("hold", {4'd0, quotient_mantissa, normalised, round_carry, div_by_zero, out_valid, in_ready},
             {4'd0, held.mant, held.norm, held.rc, held.dbz, 1'b1, 1'b0});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release", {30'd0, out_valid, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk("release_idle", {30'd0, out_valid, in_ready}, 32'd1);

      for (int i = 0; i < 8; i++) begin
         ra = {8'($urandom_range(1, 254)), 23'($urandom)};
         rb = {8'($urandom_range(1, 254)), 23'($urandom)};
         run(ra, rb, model(ra, rb));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
